fpu_seq: RTL and testbench
==========================

FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT-state cycle limit (used only under FPU_SEQ_TIMEOUT_EN).
REQ-003 SHALL have ports as listed; one clock; reset is asynchronous and active-high:
 clk  in  1  rising-edge clock
 reset  in  1  asynchronous active-high reset
 issue_i  in  1  FP ALU instruction present in E stage
 flush_i  in  1  E-stage flush (branch/jump taken)
 op_i  in  2  00 fadd, 01 fsub, 10 fmul, 11 fdiv
 fp16_i  in  1  half-precision mode
 opa_i, opb_i  in  WIDTH  forwarded operands
 fpu_start_o  out  1  one-cycle start pulse to falu
 fpu_opa_o, fpu_opb_o  out  WIDTH  latched operands to falu
 fpu_op_o  out  2  latched op code
 fpu_fp16_o  out  1  latched mode
 fpu_result_i  in  WIDTH  falu result
 fpu_valid_i  in  1  falu result valid
 fpu_flags_i  in  5  falu flags {NV,DZ,OF,UF,NX}
 stall_o  out  1  hold F/D/E stages
 result_o  out  WIDTH  captured result
 result_valid_o  out  1  result_o valid this cycle
 fflags_o  out  5  sticky accumulated flags
 clr_flags_i  in  1  clear sticky flags
 busy_o  out  1  state not IDLE
 timeout_o  out  1  sticky watchdog indication

Function
REQ-004 SHALL implement states IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-005 IDLE: issue_i=1 and flush_i=0 -> latch opa/opb/op/fp16, go ISSUE; stall_o=1 combinationally in that same cycle.
REQ-006 ISSUE: fpu_start_o=1 for exactly one cycle, stall_o=1, go WAIT.
REQ-007 WAIT: stall_o=1; fpu_valid_i=1 -> capture fpu_result_i into result_o, OR fpu_flags_i into fflags_o, go DONE.
REQ-008 DONE: result_valid_o=1, stall_o=0 for one cycle, go IDLE; result_o holds until next capture.
REQ-009 flush_i=1 in ISSUE -> IDLE, no start pulse issued; in WAIT -> DRAIN, stall_o=0.
REQ-010 DRAIN: stall_o=0; wait fpu_valid_i, discard result and flags, go IDLE; issue_i during DRAIN is held off by stall_o=1 until return to IDLE.
REQ-011 fpu_valid_i SHALL be ignored in IDLE, ISSUE, DONE.
REQ-012 clr_flags_i and flag update in same cycle -> new flags survive (clear then OR).
REQ-013 fpu_start_o SHALL never assert while a falu operation is outstanding (WAIT/DRAIN).
REQ-014 busy_o = (state != IDLE).

Reset
REQ-015 Reset SHALL force IDLE; stall_o, fpu_start_o, result_valid_o, busy_o, timeout_o = 0; result_o, fpu_opa_o, fpu_opb_o = 0; fpu_op_o = 00; fpu_fp16_o = 0; fflags_o = 00000.
REQ-016 Reset mid-operation SHALL abandon the operation with no flag update.

Configuration
REQ-017 With FPU_SEQ_TIMEOUT_EN defined: cycle counter runs in WAIT/DRAIN; at TIMEOUT_CYCLES without fpu_valid_i -> WAIT goes DONE with result_o=32'h7FC00000, NV set in fflags_o, timeout_o set sticky (cleared by clr_flags_i); DRAIN goes IDLE.
REQ-018 Without FPU_SEQ_TIMEOUT_EN: no counter, WAIT/DRAIN wait indefinitely, timeout_o tied 0.

Structure
REQ-019 Package fpu_seq_pkg SHALL hold the state enum, op-code constants, flag bit indices, canonical-NaN constant.
REQ-020 Sub-module fpu_seq_wdog (watchdog counter) SHALL be instantiated only under FPU_SEQ_TIMEOUT_EN.

Verification
REQ-021 fadd 3F800000+40000000, valid 4 cycles after start -> one start pulse, stall 6 cycles, result_o=40400000, result_valid_o one cycle.
REQ-022 fdiv 1.0/0.0, flags 01000 -> fflags_o=01000; next clean op keeps 01000; clr_flags_i -> 00000.
REQ-023 flush_i in WAIT, valid 3 cycles later with result 12345678 -> stall drops, no result_valid_o, result_o unchanged, flags unchanged, IDLE afterwards.
REQ-024 issue_i+flush_i same IDLE cycle -> stays IDLE, no stall, no start.
REQ-025 FPU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, valid never -> DONE after 8 WAIT cycles, result_o=7FC00000, fflags_o[NV]=1, timeout_o=1.
REQ-026 reset asserted in WAIT -> all outputs at reset values same cycle, next issue proceeds normally.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared definitions for the FP ALU issue sequencer.
//   state_t       - sequencer FSM states
//   OP_*          - op-code encodings on op_i / fpu_op_o
//   FLAG_*        - bit positions inside the {NV,DZ,OF,UF,NX} flag vector
//   CANON_NAN     - result substituted when the watchdog abandons an op
package fpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] OP_FADD = 2'b00;
  localparam logic [1:0] OP_FSUB = 2'b01;
  localparam logic [1:0] OP_FMUL = 2'b10;
  localparam logic [1:0] OP_FDIV = 2'b11;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [4:0]  FLAG_NV_MASK = 5'b10000;
  localparam logic [31:0] CANON_NAN    = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_seq_wdog.sv
// fpu_seq_wdog: watchdog down-counter for the sequencer's outstanding-op states.
// Only instantiated when FPU_SEQ_TIMEOUT_EN is defined.
//   clk, reset  - clock, async active-high reset
//   i_run       - high while an falu op is outstanding (WAIT/DRAIN)
//   o_expire    - high in the TIMEOUT_CYCLES-th consecutive cycle of i_run
module fpu_seq_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Reloaded whenever idle so the first running cycle sees LOAD; terminal
  // count is zero, reached in the TIMEOUT_CYCLES-th running cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= LOAD;
    end else if (!i_run) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_run && (r_cnt == '0);

endmodule

// File: rtl/fpu_seq.sv
// fpu_seq: sequences one FP ALU instruction from the E stage into the falu,
// stalls the front of the pipe while it is outstanding, captures the result
// and accumulates sticky exception flags.
//   clk, reset                       - clock, async active-high reset
//   issue_i, flush_i                 - E-stage FP instruction present / killed
//   op_i, fp16_i, opa_i, opb_i       - instruction op, mode, operands
//   fpu_start_o, fpu_op_o, fpu_fp16_o,
//   fpu_opa_o, fpu_opb_o             - start pulse + latched request to falu
//   fpu_result_i, fpu_valid_i,
//   fpu_flags_i                      - falu response
//   stall_o                          - hold F/D/E
//   result_o, result_valid_o         - captured result, valid for one cycle
//   fflags_o, clr_flags_i            - sticky {NV,DZ,OF,UF,NX}, clear request
//   busy_o                           - sequencer not idle
//   timeout_o                        - sticky watchdog indication
// Optional feature: define FPU_SEQ_TIMEOUT_EN to add the WAIT/DRAIN watchdog
// (TIMEOUT_CYCLES); without it timeout_o is tied low and waits are unbounded.
//
// state | meaning
// IDLE  | no op outstanding; accepts issue_i unless flushed
// ISSUE | operands latched, start pulse to falu
// WAIT  | falu busy, pipe stalled, waiting for fpu_valid_i
// DONE  | result_o valid for one cycle, pipe released
// DRAIN | op was flushed; pipe released, discarding the late falu response
module fpu_seq
  import fpu_seq_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_i,
  input  logic             flush_i,
  input  logic [1:0]       op_i,
  input  logic             fp16_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             fpu_start_o,
  output logic [WIDTH-1:0] fpu_opa_o,
  output logic [WIDTH-1:0] fpu_opb_o,
  output logic [1:0]       fpu_op_o,
  output logic             fpu_fp16_o,
  input  logic [WIDTH-1:0] fpu_result_i,
  input  logic             fpu_valid_i,
  input  logic [4:0]       fpu_flags_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic [4:0]       fflags_o,
  input  logic             clr_flags_i,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam logic [WIDTH-1:0] NAN_W = WIDTH'(CANON_NAN);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("fpu_seq: TIMEOUT_CYCLES must be at least 1");
  end

  state_t           r_state;
  state_t           w_next;
  logic             w_stall;
  logic             w_start;
  logic             w_accept;
  logic             w_capture;
  logic             w_tmo;
  logic             w_expire;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [1:0]       r_op;
  logic             r_fp16;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_fflags;

`ifdef FPU_SEQ_TIMEOUT_EN
  logic r_timeout;

  fpu_seq_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .i_run    ((r_state == ST_WAIT) || (r_state == ST_DRAIN)),
    .o_expire (w_expire)
  );

  // Set wins over a same-cycle clear, matching the flag behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_timeout & ~clr_flags_i) | w_tmo;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_expire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_start   = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_tmo     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (issue_i && !flush_i) begin
          w_accept = 1'b1;
          w_stall  = 1'b1;
          w_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A flush here kills the op before the falu ever sees it.
        if (flush_i) begin
          w_next = ST_IDLE;
        end else begin
          w_start = 1'b1;
          w_stall = 1'b1;
          w_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          // A response arriving in the flush cycle is simply dropped.
          w_next = fpu_valid_i ? ST_IDLE : ST_DRAIN;
        end else if (fpu_valid_i) begin
          w_capture = 1'b1;
          w_stall   = 1'b1;
          w_next    = ST_DONE;
        end else if (w_expire) begin
          w_tmo   = 1'b1;
          w_stall = 1'b1;
          w_next  = ST_DONE;
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      ST_DRAIN: begin
        // Pipe runs, but a new FP instruction must wait for the falu to free up.
        w_stall = issue_i;
        if (fpu_valid_i || w_expire) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_op     <= OP_FADD;
      r_fp16   <= 1'b0;
      r_result <= '0;
      r_fflags <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_opa  <= opa_i;
        r_opb  <= opb_i;
        r_op   <= op_i;
        r_fp16 <= fp16_i;
      end
      if (w_capture) begin
        r_result <= fpu_result_i;
      end else if (w_tmo) begin
        r_result <= NAN_W;
      end
      // Clear first, then OR, so flags raised in the clear cycle survive.
      r_fflags <= (clr_flags_i ? 5'b0 : r_fflags)
                | (w_capture ? fpu_flags_i : 5'b0)
                | (w_tmo ? FLAG_NV_MASK : 5'b0);
    end
  end

  // stall_o is combinational from issue_i in IDLE; gate it so reset forces it low.
  assign stall_o        = w_stall & ~reset;
  assign fpu_start_o    = w_start;
  assign fpu_opa_o      = r_opa;
  assign fpu_opb_o      = r_opb;
  assign fpu_op_o       = r_op;
  assign fpu_fp16_o     = r_fp16;
  assign result_o       = r_result;
  assign result_valid_o = (r_state == ST_DONE);
  assign fflags_o       = r_fflags;
  assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpu_seq.sv
module tb_fpu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_i, flush_i, fp16_i, fpu_valid_i, clr_flags_i;
  logic [1:0]  op_i;
  logic [31:0] opa_i, opb_i, fpu_result_i;
  logic [4:0]  fpu_flags_i;
  logic        fpu_start_o, fpu_fp16_o, stall_o, result_valid_o, busy_o, timeout_o;
  logic [31:0] fpu_opa_o, fpu_opb_o, result_o;
  logic [1:0]  fpu_op_o;
  logic [4:0]  fflags_o;

  fpu_seq #(.WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .issue_i(issue_i), .flush_i(flush_i), .op_i(op_i),
    .fp16_i(fp16_i), .opa_i(opa_i), .opb_i(opb_i), .fpu_start_o(fpu_start_o),
    .fpu_opa_o(fpu_opa_o), .fpu_opb_o(fpu_opb_o), .fpu_op_o(fpu_op_o),
    .fpu_fp16_o(fpu_fp16_o), .fpu_result_i(fpu_result_i), .fpu_valid_i(fpu_valid_i),
    .fpu_flags_i(fpu_flags_i), .stall_o(stall_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .fflags_o(fflags_o), .clr_flags_i(clr_flags_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: what the sequencer should be showing between operations.
  logic [31:0] m_result;
  logic [4:0]  m_flags;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, res;
    logic [4:0]  fl;
    int          lat;     // WAIT cycle (counted from 1 after the start pulse) carrying valid
    int          fat;     // WAIT cycle carrying flush, 0 = no flush
    bit          clr;     // clear flags in the valid cycle
    int          e_stall;
    bit          e_rv;
    logic [31:0] e_res;
    logic [4:0]  e_flags;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input  logic [1:0]  op, input logic [31:0] a, input logic [31:0] b, input logic fp16,
    input  logic [31:0] res, input logic [4:0] fl, input int lat, input int fat, input bit clr,
    output int n_stall, output int n_start, output int n_rv, output logic [31:0] rv_res,
    output bit opnd_ok, output bit done_ok);
    int t;
    bit started, issuing, start_now;
    t = 0; started = 0; issuing = 1;
    n_stall = 0; n_start = 0; n_rv = 0; rv_res = '0; opnd_ok = 0; done_ok = 0;
    op_i = op; opa_i = a; opb_i = b; fp16_i = fp16; fpu_result_i = res;
    for (int cyc = 0; cyc < 80; cyc++) begin
      issue_i     = issuing;
      flush_i     = started && (fat != 0) && (t == fat);
      fpu_valid_i = started && (t == lat);
      fpu_flags_i = (started && (t == lat)) ? fl : 5'b0;
      clr_flags_i = clr && started && (t == lat);
      #3;
      if (stall_o) n_stall++;
      start_now = fpu_start_o;
      if (start_now) begin
        n_start++;
        opnd_ok = (fpu_opa_o == a) && (fpu_opb_o == b) && (fpu_op_o == op) && (fpu_fp16_o == fp16);
      end
      if (result_valid_o) begin
        n_rv++;
        rv_res = result_o;
      end
      if (flush_i || !stall_o) issuing = 0;
      step();
      if (started && (t == lat + 1)) begin
        done_ok = 1;
        break;
      end
      if (started) t++;
      else if (start_now) begin
        started = 1;
        t = 1;
      end
    end
    issue_i = 0; flush_i = 0; fpu_valid_i = 0; fpu_flags_i = 0; clr_flags_i = 0;
  endtask

  task automatic op_check(
    input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
    input logic fp16, input logic [31:0] res, input logic [4:0] fl, input int lat,
    input int fat, input bit clr, input int e_stall, input bit e_rv,
    input logic [31:0] e_res, input logic [4:0] e_flags);
    int ns, nst, nrv;
    logic [31:0] rvr;
    bit ook, dok;
    run_op(op, a, b, fp16, res, fl, lat, fat, clr, ns, nst, nrv, rvr, ook, dok);
    chk({tag, "_done"},   32'(dok), 32'd1);
    chk({tag, "_starts"}, 32'(nst), 32'd1);
    chk({tag, "_opnds"},  32'(ook), 32'd1);
    chk({tag, "_stall"},  32'(ns),  32'(e_stall));
    chk({tag, "_rvcnt"},  32'(nrv), 32'(e_rv));
    if (e_rv) chk({tag, "_rvres"}, rvr, e_res);
    chk({tag, "_result"}, result_o, e_res);
    chk({tag, "_flags"},  32'(fflags_o), 32'(e_flags));
    chk({tag, "_busy"},   32'(busy_o), 32'd0);
  endtask

  initial begin
    reset = 1; issue_i = 0; flush_i = 0; fpu_valid_i = 0; clr_flags_i = 0;
    op_i = 0; fp16_i = 0; opa_i = 0; opb_i = 0; fpu_result_i = 0; fpu_flags_i = 0;

    // Directed vectors: {op, a, b, falu result, falu flags, lat, flush, clr, expectations}
    vecs[0] = '{2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 5'b00000, 4, 0, 0, 6, 1, 32'h40400000, 5'b00000};
    vecs[1] = '{2'b11, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 3, 0, 0, 5, 1, 32'h7F800000, 5'b01000};
    vecs[2] = '{2'b10, 32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000, 2, 0, 0, 4, 1, 32'h40C00000, 5'b01000};
    vecs[3] = '{2'b01, 32'h40A00000, 32'h3F800000, 32'h12345678, 5'b11111, 4, 1, 0, 2, 0, 32'h40C00000, 5'b01000};
    vecs[4] = '{2'b00, 32'h3F000000, 32'h3F000000, 32'h3F800000, 5'b00001, 1, 0, 1, 3, 1, 32'h3F800000, 5'b00001};

    repeat (2) @(posedge clk);
    #3;
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_start", 32'(fpu_start_o), 0);
    chk("rst_rv", 32'(result_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_tmo", 32'(timeout_o), 0);
    chk("rst_result", result_o, 0);
    chk("rst_opa", fpu_opa_o, 0);
    chk("rst_opb", fpu_opb_o, 0);
    chk("rst_op", 32'(fpu_op_o), 0);
    chk("rst_fp16", 32'(fpu_fp16_o), 0);
    chk("rst_flags", 32'(fflags_o), 0);
    reset = 0;
    step();
    m_result = 0;
    m_flags  = 0;

    for (int i = 0; i < 5; i++) begin
      op_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].res,
               vecs[i].fl, vecs[i].lat, vecs[i].fat, vecs[i].clr, vecs[i].e_stall,
               vecs[i].e_rv, vecs[i].e_res, vecs[i].e_flags);
      m_result = vecs[i].e_res;
      m_flags  = vecs[i].e_flags;
    end

    // Standalone flag clear.
    clr_flags_i = 1;
    step();
    clr_flags_i = 0;
    #3 chk("clr_flags", 32'(fflags_o), 0);
    m_flags = 0;
    step();

    // issue and flush in the same IDLE cycle.
    issue_i = 1; flush_i = 1;
    #3 chk("idle_flush_stall", 32'(stall_o), 0);
    chk("idle_flush_start", 32'(fpu_start_o), 0);
    step();
    issue_i = 0; flush_i = 0;
    #3 chk("idle_flush_busy", 32'(busy_o), 0);
    chk("idle_flush_start2", 32'(fpu_start_o), 0);
    step();

    // Flush while in ISSUE: no start pulse, back to IDLE.
    issue_i = 1; op_i = 2'b10;
    step();
    flush_i = 1;
    #3 chk("iss_flush_start", 32'(fpu_start_o), 0);
    step();
    issue_i = 0; flush_i = 0;
    #3 chk("iss_flush_busy", 32'(busy_o), 0);
    chk("iss_flush_start2", 32'(fpu_start_o), 0);
    step();

    // Flush in WAIT, new issue held off during DRAIN, late response discarded.
    op_i = 2'b10; opa_i = 32'h40000000; opb_i = 32'h3FC00000; issue_i = 1;
    #3 chk("dr_idle_stall", 32'(stall_o), 1);
    step();
    #3 chk("dr_start", 32'(fpu_start_o), 1);
    step();
    issue_i = 0; flush_i = 1;
    #3 chk("dr_flush_stall", 32'(stall_o), 0);
    step();
    flush_i = 0; issue_i = 1;
    #3 chk("drain_hold", 32'(stall_o), 1);
    chk("drain_nostart", 32'(fpu_start_o), 0);
    chk("drain_busy", 32'(busy_o), 1);
    step();
    fpu_valid_i = 1; fpu_result_i = 32'h12345678; fpu_flags_i = 5'b11111;
    #3 chk("drain_rv", 32'(result_valid_o), 0);
    step();
    fpu_valid_i = 0; fpu_flags_i = 0;
    #3 chk("drain_idle", 32'(busy_o), 0);
    chk("drain_result", result_o, m_result);
    chk("drain_flags", 32'(fflags_o), 32'(m_flags));
    chk("drain_reissue_stall", 32'(stall_o), 1);
    step();
    issue_i = 0;
    #3 chk("drain_reissue_start", 32'(fpu_start_o), 1);
    step();
    fpu_valid_i = 1; fpu_result_i = 32'h3FC00000;
    step();
    fpu_valid_i = 0;
    #3 chk("reissue_rv", 32'(result_valid_o), 1);
    chk("reissue_result", result_o, 32'h3FC00000);
    m_result = 32'h3FC00000;
    step();

`ifdef FPU_SEQ_TIMEOUT_EN
    begin
      int t, t_rv;
      t = -1; t_rv = -1;
      op_i = 2'b11; issue_i = 1;
      for (int c = 0; c < 40; c++) begin
        #3;
        if (fpu_start_o) t = 0;
        if (result_valid_o && t_rv < 0) t_rv = t;
        step();
        issue_i = 0;
        if (t_rv >= 0) break;
        if (t >= 0) t++;
      end
      chk("tmo_done_cycle", 32'(t_rv), 32'd9);
      chk("tmo_result", result_o, 32'h7FC00000);
      chk("tmo_nv", 32'(fflags_o[4]), 1);
      chk("tmo_flag", 32'(timeout_o), 1);
      clr_flags_i = 1;
      step();
      clr_flags_i = 0;
      #3 chk("tmo_clr", 32'(timeout_o), 0);
      chk("tmo_clr_flags", 32'(fflags_o), 0);
      step();
      m_result = 32'h7FC00000;
      m_flags  = 0;
    end
`else
    op_check("longwait", 2'b00, 32'h41000000, 32'h40000000, 1'b0, 32'h41200000, 5'b00000,
             20, 0, 0, 22, 1, 32'h41200000, m_flags);
    m_result = 32'h41200000;
    chk("longwait_tmo", 32'(timeout_o), 0);
`endif

    // Reset while in WAIT, then a normal op.
    op_i = 2'b01; opa_i = 32'h40490FDB; opb_i = 32'h3F800000; fp16_i = 1; issue_i = 1;
    step();
    issue_i = 0;
    step();
    step();
    step();
    issue_i = 1;
    reset = 1;
    #1;
    chk("wrst_stall", 32'(stall_o), 0);
    chk("wrst_start", 32'(fpu_start_o), 0);
    chk("wrst_rv", 32'(result_valid_o), 0);
    chk("wrst_busy", 32'(busy_o), 0);
    chk("wrst_tmo", 32'(timeout_o), 0);
    chk("wrst_result", result_o, 0);
    chk("wrst_opa", fpu_opa_o, 0);
    chk("wrst_opb", fpu_opb_o, 0);
    chk("wrst_op", 32'(fpu_op_o), 0);
    chk("wrst_fp16", 32'(fpu_fp16_o), 0);
    chk("wrst_flags", 32'(fflags_o), 0);
    issue_i = 0; fp16_i = 0;
    @(posedge clk);
    #3 reset = 0;
    step();
    m_result = 0;
    m_flags  = 0;
    op_check("post_rst", 2'b10, 32'h40400000, 32'h40400000, 1'b0, 32'h41100000, 5'b00001,
             2, 0, 0, 4, 1, 32'h41100000, 5'b00001);
    m_result = 32'h41100000;
    m_flags  = 5'b00001;

    // Randomized ops against the operation-level model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b, r_res;
      logic [4:0]  r_fl;
      logic        r_fp16;
      int          r_lat, r_fat, e_stall;
      bit          r_clr, flushed;
      r_op   = 2'($urandom_range(0, 3));
      r_a    = $urandom;
      r_b    = $urandom;
      r_res  = $urandom;
      r_fl   = 5'($urandom_range(0, 31)) & (($urandom_range(0, 2) == 0) ? 5'b11111 : 5'b00000);
      r_fp16 = 1'($urandom_range(0, 1));
      r_lat  = $urandom_range(1, 6);
      r_fat  = (r_lat > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, r_lat - 1) : 0;
      r_clr  = ($urandom_range(0, 9) == 0);
      flushed = (r_fat != 0);
      e_stall = flushed ? r_fat + 1 : r_lat + 2;
      if (!flushed) m_result = r_res;
      m_flags = (r_clr ? 5'b0 : m_flags) | (flushed ? 5'b0 : r_fl);
      op_check($sformatf("rnd%0d", i), r_op, r_a, r_b, r_fp16, r_res, r_fl, r_lat, r_fat,
               r_clr, e_stall, !flushed, m_result, m_flags);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
